synaptic_processing_unit3: RTL

Parametrised successor synaptic processing unit. It pops one spiking-neuron source tag from the spike FIFO and sweeps every destination neuron, LANES destinations per group. For each group it reads weights and current i_next values, adds them with signed saturation, and writes the results back to the i_next accumulator memory. It is fully synchronous on clk, and it honours write back-pressure from the accumulator-memory arbiter shared with the neuron update unit.

---
 rtl/spu_pkg.sv | 22 ++
 rtl/spu_sat_adder.sv | 24 ++
 rtl/synaptic_processing_unit3.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared definitions for the synaptic processing unit: one-hot state
// encoding, state vector width and the lane-slice index helper.
package spu_pkg;

    localparam int STATE_W = 6;

    // One-hot FSM encoding; the raw vector is also exported on the debug port.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 6'b000001,
        ST_DEQ     = 6'b000010,
        ST_READ    = 6'b000100,
        ST_CAPTURE = 6'b001000,
        ST_ADD     = 6'b010000,
        ST_WRITE   = 6'b100000
    } spu_state_t;

    // Lowest bit index of a lane inside a packed multi-lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spu_sat_adder.sv
// Signed two's-complement adder that clamps to the DATA_W range instead of
// wrapping. Purely combinational; the caller registers the result.
module spu_sat_adder #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W:0] wide;

    // Add with one guard bit; disagreeing top two bits mean overflow, and the guard bit gives its direction.
    always_comb begin
        wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sum = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sum = wide[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/synaptic_processing_unit3.sv
// Synaptic processing unit: pops one source spike tag, then sweeps all
// destination neurons LANES at a time, adding weight to i_next with
// saturation and writing back under arbiter back-pressure.
// Build option: define SPU_SKIP_ZERO_EN to skip the write-back of groups
// whose weights are all zero.
module synaptic_processing_unit3
    import spu_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int LANES       = 2,
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 2
) (
    input  logic                    clk,
    input  logic                    asyn_reset,
    input  logic                    fifo_empty,
    output logic                    fifo_deq,
    input  logic [TAG_W-1:0]        src_tag_in,
    output logic [TAG_W-1:0]        src_tag_out,
    output logic [TAG_W-1:0]        dst_base_out,
    output logic                    rd_en,
    input  logic [LANES*DATA_W-1:0] weight_in,
    input  logic [LANES*DATA_W-1:0] i_next_in,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [LANES*DATA_W-1:0] i_next_out,
    output logic                    busy,
    output logic [STATE_W-1:0]      state
);

`ifdef SPU_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    spu_state_t              cur_state;
    logic [LANES*DATA_W-1:0] weight_q;
    logic [LANES*DATA_W-1:0] i_next_q;
    logic [LANES*DATA_W-1:0] sum_w;
    logic [TAG_W:0]          next_base;
    logic                    last_group;
    logic                    zero_weights;

    // One extra bit so base+LANES cannot wrap back to zero on the last group.
    assign next_base    = {1'b0, dst_base_out} + (TAG_W+1)'(LANES);
    assign last_group   = (next_base == (TAG_W+1)'(NUM_NEURONS));
    assign zero_weights = (weight_q == '0);

    // Strobes and status are decoded straight from the state register, so they carry no input paths.
    assign fifo_deq = (cur_state == ST_DEQ);
    assign rd_en    = (cur_state == ST_READ);
    assign wr_en    = (cur_state == ST_WRITE);
    assign busy     = (cur_state != ST_IDLE);
    assign state    = cur_state;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        spu_sat_adder #(.DATA_W(DATA_W)) u_add (
            .a   (weight_q[lane_lo(g, DATA_W) +: DATA_W]),
            .b   (i_next_q[lane_lo(g, DATA_W) +: DATA_W]),
            .sum (sum_w[lane_lo(g, DATA_W) +: DATA_W])
        );
    end

    // Sweep controller: dequeue, then read/capture/add/write per destination group.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            // NOTE: the capture registers are ordinary flops, not RAM, so they are cleared along with the FSM.
            cur_state    <= ST_IDLE;
            src_tag_out  <= '0;
            dst_base_out <= '0;
            i_next_out   <= '0;
            weight_q     <= '0;
            i_next_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            unique case (cur_state)
                ST_IDLE: begin
                    if (!fifo_empty) cur_state <= ST_DEQ;
                end
                ST_DEQ: begin
                    src_tag_out  <= src_tag_in;
                    dst_base_out <= '0;
                    cur_state    <= ST_READ;
                end
                ST_READ: begin
                    cur_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    weight_q  <= weight_in;
                    i_next_q  <= i_next_in;
                    cur_state <= ST_ADD;
                end
                ST_ADD: begin
                    i_next_out <= sum_w;
                    if (SKIP_ZERO && zero_weights) begin
                        if (last_group) begin
                            cur_state <= ST_IDLE;
                        end else begin
                            dst_base_out <= next_base[TAG_W-1:0];
                            cur_state    <= ST_READ;
                        end
                    end else begin
                        cur_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (last_group) begin
                            cur_state <= ST_IDLE;
                        end else begin
                            dst_base_out <= next_base[TAG_W-1:0];
                            cur_state    <= ST_READ;
                        end
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

endmodule
